// File: rtl/sarray_ctrl_pkg.sv
// sarray_ctrl_pkg: shared encodings and defaults for the tile sequencer.
// The ST state only exists when SARRAY_CTRL_STOREC_EN is defined.
package sarray_ctrl_pkg;

  localparam int ADDR_W_D = 64;
  localparam int LOAD_W_D = 256;
  localparam int PREC_W_D = 2;

  typedef enum logic [1:0] {
    TI_TMMA     = 2'd0,
    TI_PRELOADA = 2'd1,
    TI_STOREC   = 2'd2,
    TI_RSVD     = 2'd3
  } tinst_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
`ifdef SARRAY_CTRL_STOREC_EN
    S_ST   = 2'd3,
`endif
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sarray_abuf.sv
// sarray_abuf: double-buffered A row store, 2 banks of ROWS rows.
// One write port, one read port with 1-cycle registered read.
module sarray_abuf #(
  parameter int ROWS   = 64,
  parameter int LOAD_W = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    wbank,
  input  logic [$clog2(ROWS)-1:0] waddr,
  input  logic [LOAD_W-1:0]       wdata,
  input  logic                    re,
  input  logic                    rbank,
  input  logic [$clog2(ROWS)-1:0] raddr,
  output logic [LOAD_W-1:0]       rdata
);

  logic [LOAD_W-1:0] mem [2][ROWS];

  // row write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  // registered read, held between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[rbank][raddr];
  end

endmodule

// File: rtl/sarray_ctrl.sv
// sarray_ctrl: PRELOADA/TMMA/STOREC sequencer for the systolic array.
// Build option SARRAY_CTRL_STOREC_EN enables the STOREC write path.
module sarray_ctrl
  import sarray_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int LOAD_W  = LOAD_W_D,
  parameter int STORE_W = 256,
  parameter int ROWS    = 64,
  parameter int STRIDE  = 256,
  parameter int MAX_OUT = 8,
  parameter int PREC_W  = PREC_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid_i,
  output logic                    inst_ready_o,
  input  logic [1:0]              inst_type_i,
  input  logic [ADDR_W-1:0]       inst_addr0_i,
  input  logic [ADDR_W-1:0]       inst_addr1_i,
  input  logic [PREC_W-1:0]       inst_precision_i,
  input  logic                    inst_acc_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_W-1:0]       ar_addr_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [LOAD_W-1:0]       r_data_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_W-1:0]       aw_addr_o,
  output logic [STORE_W-1:0]      aw_data_o,
  output logic                    arr_valid_o,
  output logic [LOAD_W-1:0]       arr_a_o,
  output logic [LOAD_W-1:0]       arr_b_o,
  output logic [$clog2(ROWS)-1:0] arr_cnt_o,
  output logic                    arr_acc_o,
  output logic [PREC_W-1:0]       arr_prec_o,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [STORE_W-1:0]      res_data_i,
  output logic                    done_o,
  output logic [1:0]              done_type_o
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int AW = $clog2(ROWS);
  localparam int OW = $clog2(MAX_OUT + 1);

  state_e            state, state_n;
  tinst_e            typ_q;
  logic [ADDR_W-1:0] a0_q, a1_q, base;
  logic [PREC_W-1:0] prec_q;
  logic              acc_q, sel_q;
  logic [CW-1:0]     ar_cnt, r_cnt;
  logic [OW-1:0]     outs;
  logic              accept, in_rd, is_mm;
  logic              ar_hsk, r_hsk, feed;
  logic              arr_vld_q;
  logic [LOAD_W-1:0] b_q;
  logic [AW-1:0]     arr_cnt_q;
  logic              aw_hsk;
  logic [CW-1:0]     st_cnt;

  assign accept = (state == S_IDLE) && inst_valid_i;
  assign in_rd  = (state == S_RD);
  assign is_mm  = (typ_q == TI_TMMA);
  assign base   = is_mm ? a1_q : a0_q;

  assign inst_ready_o = (state == S_IDLE);
  assign r_ready_o    = 1'b1;
  assign ar_valid_o   = in_rd && (ar_cnt < CW'(ROWS))
                        && (outs < OW'(MAX_OUT));
  assign ar_addr_o    = base
                        + ADDR_W'(ar_cnt) * ADDR_W'(STRIDE);
  assign ar_hsk       = ar_valid_o && ar_ready_i;
  // a beat only counts against a request of this instruction
  assign r_hsk        = in_rd && r_valid_i && (outs != '0);
  assign feed         = r_hsk && is_mm;

  assign arr_valid_o  = arr_vld_q;
  assign arr_b_o      = b_q;
  assign arr_cnt_o    = arr_cnt_q;
  assign arr_acc_o    = acc_q;
  assign arr_prec_o   = prec_q;
  assign done_o       = (state == S_DONE);
  assign done_type_o  = typ_q;

  sarray_abuf #(
    .ROWS   (ROWS),
    .LOAD_W (LOAD_W)
  ) u_abuf (
    .clk   (clk),
    .rst   (rst),
    .we    (r_hsk && !is_mm),
    .wbank (~sel_q),
    .waddr (r_cnt[AW-1:0]),
    .wdata (r_data_i),
    .re    (feed),
    .rbank (sel_q),
    .raddr (r_cnt[AW-1:0]),
    .rdata (arr_a_o)
  );

`ifdef SARRAY_CTRL_STOREC_EN
  logic in_st;

  assign in_st       = (state == S_ST);
  assign aw_valid_o  = in_st && res_valid_i;
  assign res_ready_o = in_st && aw_ready_i;
  assign aw_hsk      = aw_valid_o && aw_ready_i;
  assign aw_addr_o   = a0_q
                       + ADDR_W'(st_cnt) * ADDR_W'(STRIDE);
  assign aw_data_o   = in_st ? res_data_i : '0;

  // result row counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_cnt <= '0;
    else if (state == S_DONE) st_cnt <= '0;
    else if (aw_hsk) st_cnt <= st_cnt + 1'b1;
  end
`else
  logic unused_st;

  assign aw_valid_o  = 1'b0;
  assign res_ready_o = 1'b0;
  assign aw_addr_o   = '0;
  assign aw_data_o   = '0;
  assign aw_hsk      = 1'b0;
  assign st_cnt      = '0;
  assign unused_st   = ^{res_valid_i, aw_ready_i,
                         res_data_i, aw_hsk, st_cnt};
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (inst_valid_i) begin
          unique case (tinst_e'(inst_type_i))
            TI_TMMA, TI_PRELOADA: state_n = S_RD;
`ifdef SARRAY_CTRL_STOREC_EN
            TI_STOREC:            state_n = S_ST;
`endif
            default:              state_n = S_DONE;
          endcase
        end
      end
      S_RD: begin
        if (r_cnt == CW'(ROWS)) state_n = S_DONE;
      end
`ifdef SARRAY_CTRL_STOREC_EN
      S_ST: begin
        if (aw_hsk && st_cnt == CW'(ROWS - 1))
          state_n = S_DONE;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // instruction latch, read counters and bank select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      typ_q  <= TI_TMMA;
      a0_q   <= '0;
      a1_q   <= '0;
      prec_q <= '0;
      acc_q  <= 1'b0;
      sel_q  <= 1'b0;
      ar_cnt <= '0;
      r_cnt  <= '0;
      outs   <= '0;
    end else begin
      if (accept) begin
        typ_q  <= tinst_e'(inst_type_i);
        a0_q   <= inst_addr0_i;
        a1_q   <= inst_addr1_i;
        prec_q <= inst_precision_i;
        acc_q  <= inst_acc_i;
      end
      if (state == S_DONE) begin
        ar_cnt <= '0;
        r_cnt  <= '0;
        outs   <= '0;
        if (typ_q == TI_PRELOADA) sel_q <= ~sel_q;
      end else begin
        ar_cnt <= ar_cnt + CW'(ar_hsk);
        r_cnt  <= r_cnt + CW'(r_hsk);
        outs   <= outs + OW'(ar_hsk) - OW'(r_hsk);
      end
    end
  end

  // array feed: B delayed to line up with the A store read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_vld_q <= 1'b0;
      b_q       <= '0;
      arr_cnt_q <= '0;
    end else begin
      arr_vld_q <= feed;
      if (feed) begin
        b_q       <= r_data_i;
        arr_cnt_q <= r_cnt[AW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sarray_ctrl.sv
// tb_sarray_ctrl: directed bench for sarray_ctrl, ROWS=4, MAX_OUT=2.
// Memory answers each read 3 cycles after its request.
module tb_sarray_ctrl;

  logic         clk, rst;
  logic         inst_valid_i, inst_ready_o;
  logic [1:0]   inst_type_i;
  logic [63:0]  inst_addr0_i, inst_addr1_i;
  logic [1:0]   inst_precision_i;
  logic         inst_acc_i;
  logic         ar_valid_o, ar_ready_i;
  logic [63:0]  ar_addr_o;
  logic         r_valid_i, r_ready_o;
  logic [255:0] r_data_i;
  logic         aw_valid_o, aw_ready_i;
  logic [63:0]  aw_addr_o;
  logic [255:0] aw_data_o;
  logic         arr_valid_o;
  logic [255:0] arr_a_o, arr_b_o;
  logic [1:0]   arr_cnt_o;
  logic         arr_acc_o;
  logic [1:0]   arr_prec_o;
  logic         res_valid_i, res_ready_o;
  logic [255:0] res_data_i;
  logic         done_o;
  logic [1:0]   done_type_o;

  sarray_ctrl #(
    .ADDR_W(64), .LOAD_W(256), .STORE_W(256), .ROWS(4),
    .STRIDE(256), .MAX_OUT(2), .PREC_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_type_i(inst_type_i),
    .inst_addr0_i(inst_addr0_i), .inst_addr1_i(inst_addr1_i),
    .inst_precision_i(inst_precision_i), .inst_acc_i(inst_acc_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_data_o(aw_data_o),
    .arr_valid_o(arr_valid_o), .arr_a_o(arr_a_o), .arr_b_o(arr_b_o),
    .arr_cnt_o(arr_cnt_o), .arr_acc_o(arr_acc_o),
    .arr_prec_o(arr_prec_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_data_i(res_data_i),
    .done_o(done_o), .done_type_o(done_type_o)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } rq_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int viol = 0;
  int acc_cyc = 0;
  int res_idx = 0;
  bit resp_en = 1'b1;
  bit chk_out = 1'b0;
  bit store_on = 1'b0;

  logic [255:0] mem [logic [63:0]];
  rq_t          rq [$];
  logic [63:0]  ar_log [$];
  int           ar_cyc [$];
  int           r_cyc [$];
  logic [255:0] arr_a_log [$];
  logic [255:0] arr_b_log [$];
  int           arr_cnt_log [$];
  int           arr_cyc_log [$];
  logic [2:0]   arr_pa_log [$];
  logic [63:0]  aw_addr_log [$];
  logic [255:0] aw_data_log [$];
  int           done_cyc_log [$];
  logic [1:0]   done_typ_log [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory / result-source model and output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && rq.size() > 0 && rq[0].due <= cyc) begin
        r_valid_i = 1'b1;
        r_data_i = mem.exists(rq[0].addr) ? mem[rq[0].addr] : '0;
        void'(rq.pop_front());
        r_cyc.push_back(cyc);
      end else begin
        r_valid_i = 1'b0;
        r_data_i = '0;
      end
      if (store_on) begin
        aw_ready_i = ~aw_ready_i;
        res_valid_i = (res_idx < 4);
        res_data_i = 256'h5000 + 256'(res_idx);
      end else begin
        res_valid_i = 1'b0;
        res_data_i = '0;
      end
      #2;
      if (inst_valid_i && inst_ready_o) acc_cyc = cyc;
      if (chk_out && ar_valid_o
          && (rq.size() + int'(r_valid_i)) >= 2) viol++;
      if (ar_valid_o && ar_ready_i) begin
        rq.push_back('{addr: ar_addr_o, due: cyc + 3});
        ar_log.push_back(ar_addr_o);
        ar_cyc.push_back(cyc);
      end
      if (arr_valid_o) begin
        arr_a_log.push_back(arr_a_o);
        arr_b_log.push_back(arr_b_o);
        arr_cnt_log.push_back(int'(arr_cnt_o));
        arr_cyc_log.push_back(cyc);
        arr_pa_log.push_back({arr_acc_o, arr_prec_o});
      end
      if (aw_valid_o && aw_ready_i) begin
        aw_addr_log.push_back(aw_addr_o);
        aw_data_log.push_back(aw_data_o);
        res_idx++;
      end
      if (done_o) begin
        done_cyc_log.push_back(cyc);
        done_typ_log.push_back(done_type_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"},
        {inst_ready_o, ar_valid_o, aw_valid_o,
         arr_valid_o, res_ready_o, done_o}, 6'b100000);
    chk({tag, "_data"},
        |{ar_addr_o, aw_addr_o, aw_data_o, arr_a_o,
          arr_b_o, arr_cnt_o, done_type_o}, 1'b0);
  endtask

  task automatic clr_logs();
    ar_log.delete();
    ar_cyc.delete();
    r_cyc.delete();
    arr_a_log.delete();
    arr_b_log.delete();
    arr_cnt_log.delete();
    arr_cyc_log.delete();
    arr_pa_log.delete();
    aw_addr_log.delete();
    aw_data_log.delete();
    done_cyc_log.delete();
    done_typ_log.delete();
  endtask

  task automatic issue(input logic [1:0] t, input logic [63:0] a0,
                       input logic [63:0] a1, input logic [1:0] pr,
                       input logic ac);
    @(negedge clk);
    clr_logs();
    inst_valid_i = 1'b1;
    inst_type_i = t;
    inst_addr0_i = a0;
    inst_addr1_i = a1;
    inst_precision_i = pr;
    inst_acc_i = ac;
    @(negedge clk);
    inst_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cyc_log.size() == 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk(tag, done_cyc_log.size(), 1);
  endtask

  task automatic set_rows(input logic [63:0] b, input logic [255:0] d);
    for (int i = 0; i < 4; i++)
      mem[b + 64'(i) * 64'd256] = d + 256'(i);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    inst_valid_i = 1'b0;
    inst_type_i = 2'd0;
    inst_addr0_i = '0;
    inst_addr1_i = '0;
    inst_precision_i = '0;
    inst_acc_i = 1'b0;
    ar_ready_i = 1'b1;
    aw_ready_i = 1'b0;
    r_valid_i = 1'b0;
    r_data_i = '0;
    res_valid_i = 1'b0;
    res_data_i = '0;
    repeat (2) @(negedge clk);
    #3;
    chk_rst("reset");
    @(negedge clk);
    rst = 1'b0;

    // PRELOADA of 0xA0..0xA3 from 0x1000
    set_rows(64'h1000, 256'hA0);
    set_rows(64'h3000, 256'hB0);
    chk_out = 1'b1;
    issue(2'd1, 64'h1000, 64'h0, 2'd0, 1'b0);
    wait_done("pre1_done");
    chk("pre1_nar", ar_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("pre1_addr", ar_log[i], 64'h1000 + 64'(i) * 64'd256);
    chk("pre1_first_ar", ar_cyc[0], acc_cyc + 1);
    chk("pre1_outmax", viol, 0);
    chk("pre1_type", done_typ_log[0], 2'd1);
    chk("pre1_lat", done_cyc_log[0], r_cyc[3] + 2);
    chk("pre1_noarr", arr_cyc_log.size(), 0);
    @(negedge clk);
    #3;
    chk("pre1_ready", {inst_ready_o, done_o}, 2'b10);

    // TMMA with B rows from 0x3000
    issue(2'd0, 64'h9000, 64'h3000, 2'd2, 1'b1);
    wait_done("mm1_done");
    chk("mm1_outmax", viol, 0);
    chk("mm1_ar0", ar_log[0], 64'h3000);
    chk("mm1_nfeed", arr_cyc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("mm1_a", arr_a_log[i], 256'hA0 + 256'(i));
      chk("mm1_b", arr_b_log[i], 256'hB0 + 256'(i));
      chk("mm1_cnt", arr_cnt_log[i], i);
      chk("mm1_lat", arr_cyc_log[i], r_cyc[i] + 1);
    end
    chk("mm1_mode", arr_pa_log[0], 3'b110);
    chk("mm1_type", done_typ_log[0], 2'd0);
    chk("mm1_done_lat", done_cyc_log[0], arr_cyc_log[3] + 1);
    chk_out = 1'b0;

    // second PRELOADA (0xC*) must replace the A rows
    set_rows(64'h1000, 256'hC0);
    issue(2'd1, 64'h1000, 64'h0, 2'd0, 1'b0);
    wait_done("pre2_done");
    issue(2'd0, 64'h0, 64'h3000, 2'd1, 1'b0);
    wait_done("mm2_done");
    chk("mm2_nfeed", arr_cyc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("mm2_a", arr_a_log[i], 256'hC0 + 256'(i));
      chk("mm2_b", arr_b_log[i], 256'hB0 + 256'(i));
    end
    chk("mm2_mode", arr_pa_log[3], 3'b001);

    // STOREC to 0x2000 with aw_ready toggling
    res_idx = 0;
    aw_ready_i = 1'b0;
    store_on = 1'b1;
    issue(2'd2, 64'h2000, 64'h0, 2'd0, 1'b0);
    wait_done("st_done");
    chk("st_type", done_typ_log[0], 2'd2);
`ifdef SARRAY_CTRL_STOREC_EN
    chk("st_nwr", aw_addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("st_addr", aw_addr_log[i], 64'h2000 + 64'(i) * 64'd256);
      chk("st_data", aw_data_log[i], 256'h5000 + 256'(i));
    end
`else
    chk("st_lat", done_cyc_log[0], acc_cyc + 1);
    chk("st_nwr", aw_addr_log.size(), 0);
    chk("st_rdy", res_ready_o, 1'b0);
`endif
    store_on = 1'b0;
    aw_ready_i = 1'b0;

    // address wrap at the top of the space
    issue(2'd1, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 2'd0, 1'b0);
    wait_done("wrap_done");
    chk("wrap_a0", ar_log[0], 64'hFFFF_FFFF_FFFF_FF00);
    chk("wrap_a1", ar_log[1], 64'h0);
    chk("wrap_a2", ar_log[2], 64'h100);

    // reset mid-TMMA with two reads outstanding
    issue(2'd0, 64'h0, 64'h3000, 2'd3, 1'b1);
    n = 0;
    while (rq.size() < 2 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("rst_wait", n < 20, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    clr_logs();
    #3;
    chk_rst("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (rq.size() > 0 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    repeat (3) @(negedge clk);
    #3;
    chk("rst_drain", rq.size(), 0);
    chk("rst_nofeed", arr_cyc_log.size(), 0);
    chk("rst_nodone", done_cyc_log.size(), 0);
    chk("rst_noar", ar_log.size(), 0);
    chk_rst("rst_idle");

    // PRELOADA then TMMA after the reset
    set_rows(64'h1000, 256'hD0);
    issue(2'd1, 64'h1000, 64'h0, 2'd0, 1'b0);
    wait_done("post_done");
    chk("post_type", done_typ_log[0], 2'd1);
    chk("post_nar", ar_log.size(), 4);
    chk("post_a3", ar_log[3], 64'h1300);
    issue(2'd0, 64'h0, 64'h3000, 2'd0, 1'b0);
    wait_done("post_mm_done");
    chk("post_nfeed", arr_cyc_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("post_a", arr_a_log[i], 256'hD0 + 256'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
